alu_shift_sequencer: RTL and testbench

Multi-cycle controller that sequences the ALU + barrel-shifter datapath for ARM-style data-processing ops.
- Accepts one command at a time over a valid/ready handshake.
- Drives the datapath control and operand buses, waits a fixed datapath latency, then captures the result.
- Owns the architectural NZCV flag register, replacing level-triggered flag latching with clocked updates.
- Sits between instruction decode (command side) and register writeback (response side).

---
 rtl/alu_shift_sequencer.sv | 115 +++++++++++
 tb/tb_alu_shift_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Sequences the ALU + barrel-shifter datapath for one data-processing op at a time.
// Holds operands stable for DP_LATENCY cycles, captures the result and owns the NZCV flag register.
//
// state | meaning
// IDLE  | ready for a command; cmd_* latched into dp_* on accept
// EXEC  | dp_* held stable; down-counter runs to terminal count, then capture
// RESP  | rsp_* valid and stable until the consumer takes it
module alu_shift_sequencer #(
    parameter int unsigned DP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_alu_op,
    input  logic [2:0]  cmd_shift_op,
    input  logic [7:0]  cmd_shift_num,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_shift_data,
    input  logic        cmd_s,
    input  logic        cmd_ext,
    input  logic [3:0]  cmd_user_nzcv,
    output logic [3:0]  dp_alu_op,
    output logic [2:0]  dp_shift_op,
    output logic [7:0]  dp_shift_num,
    output logic [31:0] dp_a,
    output logic [31:0] dp_shift_data,
    output logic        dp_carry_in,
    output logic        dp_v_in,
    input  logic [31:0] dp_f,
    input  logic [3:0]  dp_nzcv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_f,
    output logic [3:0]  rsp_nzcv,
    output logic        rsp_wr,
    output logic [3:0]  flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DP_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            s_q           <= 1'b0;
            flags         <= '0;
            dp_alu_op     <= '0;
            dp_shift_op   <= '0;
            dp_shift_num  <= '0;
            dp_a          <= '0;
            dp_shift_data <= '0;
            rsp_f         <= '0;
            rsp_nzcv      <= '0;
            rsp_wr        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dp_alu_op     <= cmd_alu_op;
                        dp_shift_op   <= cmd_shift_op;
                        dp_shift_num  <= cmd_shift_num;
                        dp_a          <= cmd_a;
                        dp_shift_data <= cmd_shift_data;
                        s_q           <= cmd_s;
                        cnt           <= CNT_LOAD;
                        // ext load lands before EXEC so the op sees the new C/V
                        if (cmd_ext) begin
                            flags <= cmd_user_nzcv;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_f    <= dp_f;
                        rsp_nzcv <= dp_nzcv;
                        // compare class (TST/TEQ/CMP/CMN) produces flags only
                        rsp_wr   <= (dp_alu_op[3:2] != 2'b10);
                        if (s_q) begin
                            flags <= dp_nzcv;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign dp_carry_in = flags[1];
    assign dp_v_in     = flags[0];

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench: three sequencers (latency 3, 1, 15) share one command bus,
// each driving a behavioural ADD/ADC/SUB/CMP/AND + LSL datapath model.
module tb_alu_shift_sequencer;

    typedef struct {
        logic [31:0] f;
        logic [3:0]  nzcv;
        logic        wr;
        logic [3:0]  flags;
        logic [1:0]  cv_in;
        logic [78:0] ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_alu_op = '0;
    logic [2:0]  cmd_shift_op = '0;
    logic [7:0]  cmd_shift_num = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_shift_data = '0;
    logic        cmd_s = 1'b0;
    logic        cmd_ext = 1'b0;
    logic [3:0]  cmd_user_nzcv = '0;
    logic        rsp_ready = 1'b1;

    logic [2:0]  cmd_ready, busy, rsp_valid, rsp_wr, dp_carry_in, dp_v_in;
    logic [3:0]  dp_alu_op [3];
    logic [2:0]  dp_shift_op [3];
    logic [7:0]  dp_shift_num [3];
    logic [31:0] dp_a [3];
    logic [31:0] dp_shift_data [3];
    logic [31:0] dp_f [3];
    logic [3:0]  dp_nzcv [3];
    logic [31:0] rsp_f [3];
    logic [3:0]  rsp_nzcv [3];
    logic [3:0]  flags [3];

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic [2:0] seen = '0;
    logic [3:0] fl_model = '0;
    exp_t sb_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 15;
    endfunction

    function automatic logic [35:0] dp_model(input logic [3:0] alu, input logic [2:0] sop,
                                              input logic [7:0] num, input logic [31:0] a,
                                              input logic [31:0] sd, input logic cin, input logic vin);
        logic [31:0] b, f;
        logic [32:0] sum;
        logic c, v;
        if (sop == 3'd0) b = (num >= 8'd32) ? 32'd0 : (sd << num[4:0]);
        else             b = sd;
        case (alu)
            4'b0100: begin
                sum = {1'b0, a} + {1'b0, b};
                f = sum[31:0]; c = sum[32];
                v = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'b0101: begin
                sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                f = sum[31:0]; c = sum[32];
                v = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'b0010, 4'b1010: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                f = sum[31:0]; c = sum[32];
                v = (a[31] != b[31]) && (f[31] != a[31]);
            end
            default: begin
                f = a & b; c = cin; v = vin;
            end
        endcase
        return {f[31], (f == 32'd0), c, v, f};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_shift_sequencer #(.DP_LATENCY(lat_of(g))) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]),
            .cmd_alu_op(cmd_alu_op), .cmd_shift_op(cmd_shift_op),
            .cmd_shift_num(cmd_shift_num), .cmd_a(cmd_a),
            .cmd_shift_data(cmd_shift_data), .cmd_s(cmd_s),
            .cmd_ext(cmd_ext), .cmd_user_nzcv(cmd_user_nzcv),
            .dp_alu_op(dp_alu_op[g]), .dp_shift_op(dp_shift_op[g]),
            .dp_shift_num(dp_shift_num[g]), .dp_a(dp_a[g]),
            .dp_shift_data(dp_shift_data[g]), .dp_carry_in(dp_carry_in[g]),
            .dp_v_in(dp_v_in[g]), .dp_f(dp_f[g]), .dp_nzcv(dp_nzcv[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
            .rsp_f(rsp_f[g]), .rsp_nzcv(rsp_nzcv[g]), .rsp_wr(rsp_wr[g]),
            .flags(flags[g]), .busy(busy[g])
        );
        assign {dp_nzcv[g], dp_f[g]} = dp_model(dp_alu_op[g], dp_shift_op[g], dp_shift_num[g],
                                                dp_a[g], dp_shift_data[g], dp_carry_in[g], dp_v_in[g]);
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Response-side monitor: operand stability in EXEC, latency, and scoreboard pops.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (busy[i] && !rsp_valid[i] && sb_q[i].size() > 0) begin
                    chk($sformatf("dp_hold%0d", i),
                        {1'b0, dp_alu_op[i], dp_shift_op[i], dp_shift_num[i], dp_a[i], dp_shift_data[i]},
                        {1'b0, sb_q[i][0].ctl});
                    chk($sformatf("cv_in%0d", i), {dp_carry_in[i], dp_v_in[i]}, sb_q[i][0].cv_in);
                end
                if (rsp_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("latency%0d", i), cyc - acc_cyc, lat_of(i));
                end
                if (rsp_valid[i] && rsp_ready) begin
                    if (sb_q[i].size() == 0) begin
                        chk($sformatf("sb_empty%0d", i), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        chk($sformatf("rsp_f%0d", i), rsp_f[i], e.f);
                        chk($sformatf("rsp_nzcv%0d", i), rsp_nzcv[i], e.nzcv);
                        chk($sformatf("rsp_wr%0d", i), rsp_wr[i], e.wr);
                        chk($sformatf("flags%0d", i), flags[i], e.flags);
                    end
                    seen[i] = 1'b0;
                end
            end
        end
    end

    task automatic randomize_cmd();
        cmd_alu_op     = 4'($urandom);
        cmd_shift_op   = 3'($urandom);
        cmd_shift_num  = 8'($urandom);
        cmd_a          = $urandom;
        cmd_shift_data = $urandom;
        cmd_s          = 1'($urandom);
        cmd_ext        = 1'($urandom);
        cmd_user_nzcv  = 4'($urandom);
        cmd_valid      = (&busy) ? 1'($urandom) : 1'b0;
    endtask

    // Called at posedge+2 with all instances idle; accept happens on the next edge.
    task automatic drive_cmd(input logic [3:0] alu, input logic [2:0] sop, input logic [7:0] num,
                             input logic [31:0] a, input logic [31:0] sd, input logic s,
                             input logic ext, input logic [3:0] unzcv);
        exp_t e;
        logic [3:0] fl;
        logic [35:0] r;
        fl = ext ? unzcv : fl_model;
        r = dp_model(alu, sop, num, a, sd, fl[1], fl[0]);
        e.f = r[31:0];
        e.nzcv = r[35:32];
        e.wr = (alu[3:2] != 2'b10);
        e.flags = s ? r[35:32] : fl;
        e.cv_in = fl[1:0];
        e.ctl = {alu, sop, num, a, sd};
        for (int i = 0; i < 3; i++) sb_q[i].push_back(e);
        fl_model = e.flags;
        cmd_alu_op = alu; cmd_shift_op = sop; cmd_shift_num = num; cmd_a = a;
        cmd_shift_data = sd; cmd_s = s; cmd_ext = ext; cmd_user_nzcv = unzcv;
        acc_cyc = cyc + 1;
        cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #2;
            if (&cmd_ready) begin
                cmd_valid = 1'b0;
                return;
            end
            randomize_cmd();
        end
        cmd_valid = 1'b0;
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] held_f;
        logic pulsed;
        logic [3:0] ra;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_ready", cmd_ready, 3'b111);
        chk("rst_busy", busy, 3'b000);
        chk("rst_valid", rsp_valid, 3'b000);
        chk("rst_flags", flags[0], 4'd0);
        chk("rst_dp_a", dp_a[0], 32'd0);
        chk("rst_rsp_f", rsp_f[0], 32'd0);

        drive_cmd(4'b0100, 3'd0, 8'd2, 32'd5, 32'd3, 1'b1, 1'b0, 4'd0);
        wait_idle();
        drive_cmd(4'b1010, 3'd0, 8'd0, 32'd3, 32'd3, 1'b1, 1'b0, 4'd0);
        wait_idle();
        drive_cmd(4'b0101, 3'd0, 8'd0, 32'd1, 32'd1, 1'b0, 1'b1, 4'b0010);
        wait_idle();

        rsp_ready = 1'b0;
        drive_cmd(4'b0010, 3'd0, 8'd0, 32'd10, 32'd4, 1'b1, 1'b0, 4'd0);
        for (int n = 0; n < 40 && !(&rsp_valid); n++) begin
            @(posedge clk); #2;
        end
        chk("bp_all_valid", rsp_valid, 3'b111);
        held_f = rsp_f[0];
        chk("bp_f_value", held_f, 32'd6);
        for (int n = 0; n < 5; n++) begin
            randomize_cmd();
            @(posedge clk); #2;
            chk("bp_valid", rsp_valid[0], 1'b1);
            chk("bp_f", rsp_f[0], held_f);
            chk("bp_ready", cmd_ready[0], 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_ready_after", cmd_ready, 3'b111);

        drive_cmd(4'b1010, 3'd0, 8'd0, 32'd7, 32'd7, 1'b1, 1'b0, 4'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) sb_q[i].delete();
        seen = '0;
        fl_model = '0;
        chk("midrst_flags", flags[0], 4'd0);
        chk("midrst_valid", rsp_valid[0], 1'b0);
        chk("midrst_ready", cmd_ready, 3'b111);
        pulsed = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #2;
            pulsed = pulsed | rsp_valid[0];
        end
        chk("midrst_no_rsp", pulsed, 1'b0);

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0: ra = 4'b0100;
                1: ra = 4'b0101;
                2: ra = 4'b0010;
                3: ra = 4'b1010;
                default: ra = 4'b0000;
            endcase
            drive_cmd(ra, 3'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom, $urandom,
                      1'($urandom), 1'($urandom), 4'($urandom));
            wait_idle();
        end
        chk("sb_drained", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
